// File: rtl/mdu_if.sv
// Core-side handshake between the LEGv8 core and the multiply/divide sequencer.
// The core drives the request and flush; the sequencer returns status and result.
interface mdu_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            div_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result, div_zero
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative radix-2 multiply/divide sequencer sharing one shift-add/shift-subtract datapath.
// Define MDU_FAST_MUL_EN to route multiplies through a single-cycle combinational multiplier.
module mdu_sequencer #(
  parameter int XLEN = 64,
  parameter int CNTW = 7
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  // Op codes mirror ALU_CONTROL in the core's parameter file.
  localparam logic [4:0] OPMUL    = 5'd10;
  localparam logic [4:0] OPMULH   = 5'd11;
  localparam logic [4:0] OPMULHU  = 5'd12;
  localparam logic [4:0] OPMULHSU = 5'd13;
  localparam logic [4:0] OPDIV    = 5'd14;
  localparam logic [4:0] OPDIVU   = 5'd15;
  localparam logic [4:0] OPREM    = 5'd16;
  localparam logic [4:0] OPREMU   = 5'd17;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t            state, next_state;
  logic [CNTW-1:0]   count;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   result_q;
  logic              div_zero_q;

  function automatic logic valid_op(input logic [4:0] code);
    return code inside {OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  logic is_mul, signed_a, signed_b, sel_hi, sel_rem, div_by_zero, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_mul      = op_q inside {OPMUL, OPMULH, OPMULHU, OPMULHSU};
  assign signed_a    = op_q inside {OPMULH, OPMULHSU, OPDIV, OPREM};
  assign signed_b    = op_q inside {OPMULH, OPDIV, OPREM};
  assign sel_hi      = op_q inside {OPMULH, OPMULHU, OPMULHSU};
  assign sel_rem     = op_q inside {OPREM, OPREMU};
  assign div_by_zero = !is_mul && (b_q == '0);
  assign sign_a      = signed_a && a_q[XLEN-1];
  assign sign_b      = signed_b && b_q[XLEN-1];
  assign mag_a       = sign_a ? -a_q : a_q;
  assign mag_b       = sign_b ? -b_q : b_q;

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (bus.start && valid_op(bus.op)) next_state = S_PREP;
      S_PREP: begin
        if (div_by_zero) next_state = S_DONE;
`ifdef MDU_FAST_MUL_EN
        else if (is_mul) next_state = S_FIX;
`endif
        else next_state = S_RUN;
      end
      S_RUN:  if (count == CNTW'(1)) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    // Flush aborts from any state and also drops a same-cycle request in IDLE.
    if (bus.flush) next_state = S_IDLE;
  end

  // One iteration of each algorithm; acc holds {upper, lower} halves.
  logic [XLEN:0]     mul_sum, trial_rem, diff;
  logic [2*XLEN-1:0] mul_step, div_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step  = {mul_sum, acc[XLEN-1:1]};
    trial_rem = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff      = trial_rem - {1'b0, opnd};
    if (!diff[XLEN]) div_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else             div_step = {trial_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (is_mul)       fix_result = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    else if (sel_rem) fix_result = rem_fix;
    else              fix_result = quo_fix;
  end

  // NOTE: datapath registers carry no reset; they are always loaded before the FSM consumes them.
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      S_PREP: begin
        neg_q <= sign_a ^ sign_b;
        neg_r <= sign_a;
        if (is_mul) begin
          opnd <= mag_a;
`ifdef MDU_FAST_MUL_EN
          acc  <= fast_prod;
`else
          acc  <= {{XLEN{1'b0}}, mag_b};
`endif
        end else begin
          opnd <= mag_b;
          acc  <= {{XLEN{1'b0}}, mag_a};
        end
      end
      S_RUN:   acc <= is_mul ? mul_step : div_step;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= 1'b0;
      if (state == S_PREP)     count <= CNTW'(XLEN);
      else if (state == S_RUN) count <= count - CNTW'(1);
      if (!bus.flush) begin
        if (state == S_FIX) begin
          result_q <= fix_result;
        end else if (state == S_PREP && div_by_zero) begin
          result_q   <= sel_rem ? a_q : '0;
          div_zero_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = state inside {S_PREP, S_RUN, S_FIX};
  assign bus.done     = (state == S_DONE);
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule
